// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - per-channel idle-driven clock gating with glitch-free latch-based gates
`timescale 1ns/1ps
module clk_gate_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int IDLE_W      = 8,
    parameter int IDLE_THRESH = 16,
    parameter int WAKE_CYC    = 2
) (
    input  logic              free_clk,
    input  logic              reset_n,
    input  logic              test_en,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] gated_clk,
    output logic [NUM_CH-1:0] ready,
    output logic [NUM_CH-1:0] ch_gated
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_GATED = 2'd1;
    localparam logic [1:0] ST_WAKE  = 2'd2;

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_THRESH - 1);
    localparam logic [3:0]        WAKE_LOAD = 4'(WAKE_CYC - 1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]        state_q, state_d;
        logic [IDLE_W-1:0] idle_q, idle_d;
        logic [3:0]        wake_q, wake_d;
        logic              en_q, ready_q, gated_q;
        logic              en_lat;

        always_comb begin
            state_d = state_q;
            idle_d  = idle_q;
            wake_d  = wake_q;
            case (state_q)
                ST_RUN: begin
                    // Activity on the threshold cycle keeps the channel running.
                    if (req[i]) begin
                        idle_d = '0;
                    end else if (idle_q == IDLE_LAST) begin
                        state_d = ST_GATED;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
                ST_GATED: begin
                    if (req[i]) begin
                        state_d = ST_WAKE;
                        wake_d  = WAKE_LOAD;
                    end
                end
                ST_WAKE: begin
                    if (wake_q == 4'd0) begin
                        state_d = ST_RUN;
                        idle_d  = '0;
                    end else begin
                        wake_d = wake_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    idle_d  = '0;
                    wake_d  = '0;
                end
            endcase
        end

        always_ff @(posedge free_clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= ST_RUN;
                idle_q  <= '0;
                wake_q  <= '0;
                en_q    <= 1'b1;
                ready_q <= 1'b1;
                gated_q <= 1'b0;
            end else begin
                state_q <= state_d;
                idle_q  <= idle_d;
                wake_q  <= wake_d;
                en_q    <= test_en | (state_d != ST_GATED);
                ready_q <= test_en | (state_d == ST_RUN);
                gated_q <= (state_d == ST_GATED);
            end
        end

        // Enable may only change while the clock is low, so the AND never clips a high phase.
        always_latch begin
            if (!reset_n) begin
                en_lat <= 1'b1;
            end else if (!free_clk) begin
                en_lat <= en_q;
            end
        end

        assign gated_clk[i] = free_clk & en_lat;
        assign ready[i]     = ready_q;
        assign ch_gated[i]  = gated_q;
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb/tb_clk_gate_ctrl.sv - self-checking bench for clk_gate_ctrl
`timescale 1ns/1ps
module tb_clk_gate_ctrl;
    localparam int NCH    = 2;
    localparam int THRESH = 4;
    localparam int WCYC   = 2;
    localparam int HALF   = 5;

    logic           free_clk = 1'b0;
    logic           reset_n  = 1'b0;
    logic           test_en  = 1'b0;
    logic [NCH-1:0] req      = '0;
    logic [NCH-1:0] gated_clk, ready, ch_gated;

    int checks = 0;
    int errors = 0;

    clk_gate_ctrl #(.NUM_CH(NCH), .IDLE_W(8), .IDLE_THRESH(THRESH), .WAKE_CYC(WCYC)) dut (
        .free_clk (free_clk),
        .reset_n  (reset_n),
        .test_en  (test_en),
        .req      (req),
        .gated_clk(gated_clk),
        .ready    (ready),
        .ch_gated (ch_gated)
    );

    always #HALF free_clk = ~free_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a channel is sleeping, waking for some remaining cycles, or running with an idle streak.
    int m_sleep [NCH];
    int m_wleft [NCH];
    int m_streak[NCH];
    logic [NCH-1:0] m_en, m_ready, m_gated;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_sleep[c] = 0; m_wleft[c] = 0; m_streak[c] = 0;
        end
        m_en = '1; m_ready = '1; m_gated = '0;
    endtask

    task automatic model_step(input logic [NCH-1:0] r, input logic t);
        for (int c = 0; c < NCH; c++) begin
            if (m_wleft[c] > 0) begin
                m_wleft[c]--;
                m_streak[c] = 0;
            end else if (m_sleep[c] != 0) begin
                if (r[c]) begin
                    m_sleep[c] = 0;
                    m_wleft[c] = WCYC;
                end
            end else if (r[c]) begin
                m_streak[c] = 0;
            end else if (m_streak[c] + 1 >= THRESH) begin
                m_sleep[c]  = 1;
                m_streak[c] = 0;
            end else begin
                m_streak[c]++;
            end
            m_gated[c] = (m_sleep[c] != 0);
            m_en[c]    = t | (m_sleep[c] == 0);
            m_ready[c] = t | (m_sleep[c] == 0 && m_wleft[c] == 0);
        end
    endtask

    initial model_reset();

    always @(posedge free_clk) begin
        logic [NCH-1:0] r_s;
        logic           t_s, rst_s;
        r_s = req; t_s = test_en; rst_s = reset_n;
        #1;
        check("gclk_high", gated_clk, rst_s ? m_en : {NCH{1'b1}});
        if (!rst_s) model_reset();
        else        model_step(r_s, t_s);
        check("ready", ready, m_ready);
        check("ch_gated", ch_gated, m_gated);
    end

    always @(negedge free_clk) begin
        #1;
        check("gclk_low", gated_clk, '0);
    end

    int gcnt[NCH];
    time t_rise[NCH];
    bit  seen_rise[NCH];
    for (genvar g = 0; g < NCH; g++) begin : g_mon
        initial begin gcnt[g] = 0; seen_rise[g] = 0; t_rise[g] = 0; end
        always @(posedge gated_clk[g]) begin
            gcnt[g]++;
            t_rise[g]    = $time;
            seen_rise[g] = 1;
        end
        always @(negedge gated_clk[g]) begin
            if (seen_rise[g]) begin
                checks++;
                assert ($time - t_rise[g] >= HALF) else begin
                    errors++;
                    $display("FAIL pulse_width ch%0d got %0t expected >= %0d", g, $time - t_rise[g], HALF);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge free_clk);
        #2;
    endtask

    int c0, c1;

    initial begin
        // Reset: clocks run, ready high, nothing gated.
        tick(1);
        c0 = gcnt[0];
        tick(3);
        check("rst_ready", ready, 2'b11);
        check("rst_chg", ch_gated, 2'b00);
        check("rst_gclk_runs", gcnt[0] - c0, 3);

        // Release with idle requests: gated after edge 4, no edges from 5.
        reset_n = 1'b1;
        tick(3);
        check("pre_gate_chg", ch_gated, 2'b00);
        check("pre_gate_ready", ready, 2'b11);
        tick(1);
        check("gate_chg", ch_gated, 2'b11);
        check("gate_ready", ready, 2'b00);
        c0 = gcnt[0]; c1 = gcnt[1];
        tick(3);
        check("gated_no_edges0", gcnt[0] - c0, 0);
        check("gated_no_edges1", gcnt[1] - c1, 0);

        // Wake channel 0 with a one-cycle pulse.
        req = 2'b01;
        c0 = gcnt[0];
        tick(1);
        req = 2'b00;
        check("wake_chg", ch_gated, 2'b10);
        check("wake_ready", ready, 2'b00);
        check("wake_no_edge_yet", gcnt[0] - c0, 0);
        tick(1);
        check("wake_edge_back", gcnt[0] - c0, 1);
        check("wake_ready_n2", ready[0], 1'b0);
        tick(1);
        check("wake_done_ready", ready, 2'b01);

        // Request on the threshold cycle keeps channel 0 running and restarts the count.
        tick(3);
        req = 2'b01;
        tick(1);
        req = 2'b00;
        check("req_wins_chg", ch_gated[0], 1'b0);
        check("req_wins_ready", ready[0], 1'b1);
        tick(3);
        check("restart_chg", ch_gated[0], 1'b0);
        tick(1);
        check("regate_chg", ch_gated, 2'b11);

        // Test override while both gated.
        test_en = 1'b1;
        tick(1);
        check("ten_ready", ready, 2'b11);
        check("ten_chg", ch_gated, 2'b11);
        c0 = gcnt[0]; c1 = gcnt[1];
        tick(2);
        check("ten_edges0", gcnt[0] - c0, 2);
        check("ten_edges1", gcnt[1] - c1, 2);
        test_en = 1'b0;
        tick(1);
        check("ten_off_ready", ready, 2'b00);
        c0 = gcnt[0]; c1 = gcnt[1];
        tick(2);
        check("ten_off_edges", (gcnt[0] - c0) + (gcnt[1] - c1), 0);

        // Reset asserted mid-wake.
        req = 2'b01;
        tick(1);
        req = 2'b00;
        @(negedge free_clk);
        reset_n = 1'b0;
        #1;
        check("rst_wake_ready", ready[0], 1'b1);
        check("rst_wake_chg", ch_gated[0], 1'b0);
        c0 = gcnt[0];
        tick(2);
        check("rst_wake_gclk", gcnt[0] - c0, 2);
        reset_n = 1'b1;

        // Random activity, occasional test override.
        for (int k = 0; k < 400; k++) begin
            req     = NCH'($urandom_range(0, 3) == 0 ? $urandom : 0);
            test_en = ($urandom_range(0, 19) == 0);
            tick(1);
        end
        req = '0; test_en = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, the number of independent gated clock channels (>=1).
REQ-002 SHALL have parameter IDLE_W, default 8, the idle counter width in bits.
REQ-003 SHALL have parameter IDLE_THRESH, default 16, the idle cycles before gating; legal range 1..2^IDLE_W-1.
REQ-004 SHALL have parameter WAKE_CYC, default 2, the ungated cycles before ready reasserts after wake; legal range 1..15.
REQ-005 SHALL have port free_clk, input, 1 bit: the single free-running clock; all state is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port test_en, input, 1 bit: global override; all clocks are enabled while high.
REQ-008 SHALL have port req, input, NUM_CH bits: per-channel activity/wake request, synchronous to free_clk.
REQ-009 SHALL have port gated_clk, output, NUM_CH bits: per-channel gated clock.
REQ-010 SHALL have port ready, output, NUM_CH bits: channel clock is stable and the channel may accept work.
REQ-011 SHALL have port ch_gated, output, NUM_CH bits: channel FSM is in GATED.

Function
REQ-012 Each channel SHALL run an independent FSM with states RUN, GATED and WAKE, plus an IDLE_W-bit idle counter and a 4-bit wake counter.
REQ-013 RUN: req=1 SHALL clear the idle counter; req=0 SHALL increment it; when req=0 and counter==IDLE_THRESH-1, next state SHALL be GATED and the counter SHALL clear.
REQ-014 RUN: if req=1 in the same cycle the threshold would be reached, the channel SHALL stay in RUN and the counter SHALL clear (req wins).
REQ-015 GATED: req=1 SHALL move the channel to WAKE and load the wake counter with WAKE_CYC-1; req=0 SHALL hold GATED.
REQ-016 WAKE: the wake counter SHALL decrement each cycle; at 0, next state SHALL be RUN with the idle counter cleared.
REQ-017 WAKE: req changes SHALL be ignored; the wake sequence always completes.
REQ-018 en_q[i] (registered) SHALL be 1 in RUN and WAKE, 0 in GATED, and forced to 1 for all channels while test_en=1.
REQ-019 A latch transparent while free_clk is low SHALL capture en_q[i] as en_lat[i], and gated_clk[i] SHALL equal free_clk AND en_lat[i], so the gated clock is glitch-free with no runt pulses.
REQ-020 Gating latency: en_q falling at free_clk rising edge k SHALL suppress gated_clk[i] rising edges from k+1 on; en_q rising at edge k SHALL restore the gated edge at k+1.
REQ-021 ready[i] SHALL be registered and equal 1 only in RUN; it SHALL be forced to 1 while test_en=1.
REQ-022 ch_gated[i] SHALL be registered and equal 1 only in GATED, independent of test_en.
REQ-023 test_en SHALL NOT alter FSM state or counters; only en_q and ready are overridden, and deasserting test_en SHALL resume the FSM's own en_q and ready on the next edge.
REQ-024 Counters SHALL never wrap; the idle counter SHALL saturate at IDLE_THRESH-1 by construction of REQ-013.
REQ-025 Channels SHALL share no state; simultaneous events on different channels SHALL be handled independently in the same cycle.

Reset
REQ-026 While reset_n=0 (asynchronous assertion), every channel SHALL be in RUN with counters at 0, en_q=1, en_lat=1, ready=1 and ch_gated=0.
REQ-027 gated_clk SHALL toggle with free_clk during reset, so downstream synchronous resets complete.
REQ-028 Reset asserted mid-WAKE or in GATED SHALL return the channel to RUN immediately; deassertion takes effect at the next free_clk rising edge.

Verification
REQ-029 (NUM_CH=2, IDLE_THRESH=4, WAKE_CYC=2) Reset release with req=00 SHALL give ch_gated=11 and ready=00 after edge 4, and no gated_clk rising edges from edge 5.
REQ-030 Channel 0 GATED, pulse req[0] for 1 cycle at edge n SHALL give WAKE at n+1, RUN and ready[0]=1 at n+3, and gated_clk[0] edges resuming at n+2.
REQ-031 req[0]=1 exactly at idle count 3 SHALL keep channel 0 in RUN, ch_gated[0]=0, with the count restarting at 0.
REQ-032 test_en=1 while both channels are GATED SHALL make both gated_clk toggle from the next edge, ready=11 and ch_gated=11; test_en=0 SHALL stop the clocks again.
REQ-033 reset_n=0 asserted mid-WAKE SHALL give ready=1 and ch_gated=0 immediately, with gated_clk toggling.
REQ-034 Random req on all channels SHALL never produce a gated_clk high pulse shorter than free_clk high time, checked by assertion.
